// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample majority voting and
// parity, framing and break reporting.
module uart_rx_os #(
    parameter int    DATA_BITS  = 8,
    parameter int    OVERSAMPLE = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    IDLE_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 os_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(IDLE_BITS * OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam bit HAS_PAR = PARITY != "NONE";
    localparam bit ODD     = PARITY == "ODD";
    localparam logic [TW-1:0] T_LO   = TW'(M - 1);
    localparam logic [TW-1:0] T_MID  = TW'(M);
    localparam logic [TW-1:0] T_VOTE = TW'(M + 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDLE_LONG  = IW'(IDLE_BITS * OVERSAMPLE);
    localparam logic [IW-1:0] IDLE_SHORT = IW'(OVERSAMPLE);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic                 rx_m, rxs;
    logic [TW-1:0]        tcnt;
    logic [IW-1:0]        icnt;
    logic                 short_idle;
    logic [BW-1:0]        bcnt;
    logic                 scnt;
    logic [1:0]           vs;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit, stop_err, stop_zero;
    logic                 vote, last_stop;
    logic [IW-1:0]        ithr;

    // majority of the two earlier vote samples and the current one
    assign vote      = (vs[0] & vs[1]) | (rxs & (vs[0] | vs[1]));
    assign last_stop = scnt == 1'(STOP_BITS - 1);
    assign ithr      = short_idle ? IDLE_SHORT : IDLE_LONG;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rxs        <= 1'b1;
            state      <= WAIT_IDLE;
            tcnt       <= '0;
            icnt       <= '0;
            short_idle <= 1'b0;
            bcnt       <= '0;
            scnt       <= 1'b0;
            vs         <= '0;
            shreg      <= '0;
            pbit       <= 1'b0;
            stop_err   <= 1'b0;
            stop_zero  <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m     <= rx;
            rxs      <= rx_m;
            rx_valid <= 1'b0;
            if (os_tick) begin
                if (state != WAIT_IDLE && state != IDLE) begin
                    tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
                    if (tcnt == T_LO) vs[0] <= rxs;
                    if (tcnt == T_MID) vs[1] <= rxs;
                end
                case (state)
                    WAIT_IDLE: begin
                        icnt <= rxs ? icnt + 1'b1 : '0;
                        if (rxs && icnt + 1'b1 == ithr) begin
                            state <= IDLE;
                            icnt  <= '0;
                        end
                    end
                    IDLE: if (!rxs) begin
                        state <= START;
                        tcnt  <= '0;
                        busy  <= 1'b1;
                    end
                    START: begin
                        if (tcnt == T_VOTE && vote) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (tcnt == T_END) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end
                    end
                    DATA: begin
                        if (tcnt == T_VOTE) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (tcnt == T_END) begin
                            bcnt <= bcnt + 1'b1;
                            if (bcnt == BW'(DATA_BITS - 1)) begin
                                if (HAS_PAR) state <= PAR;
                                else state <= STOP;
                                scnt      <= 1'b0;
                                stop_err  <= 1'b0;
                                stop_zero <= 1'b1;
                            end
                        end
                    end
                    PAR: begin
                        if (tcnt == T_VOTE) pbit <= vote;
                        if (tcnt == T_END) state <= STOP;
                    end
                    STOP: begin
                        if (tcnt == T_VOTE && last_stop) begin
                            rx_valid   <= 1'b1;
                            busy       <= 1'b0;
                            rx_data    <= shreg;
                            parity_err <= HAS_PAR && ((^shreg ^ pbit) != ODD);
                            frame_err  <= stop_err | ~vote;
                            break_det  <= ~vote & stop_zero & ~|shreg & ~(HAS_PAR && pbit);
                            // a framing error must see one clean bit time before re-arming
                            if (stop_err | ~vote) begin
                                state      <= WAIT_IDLE;
                                short_idle <= 1'b1;
                                icnt       <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (tcnt == T_VOTE) begin
                            stop_err  <= stop_err | ~vote;
                            stop_zero <= stop_zero & ~vote;
                        end else if (tcnt == T_END) begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench driving three receiver configurations
// (8N1/OS8, 8O1/OS8, 7E2/OS16 with os_tick every cycle).
module tb_uart_rx_os;
    logic clk = 1'b0, rst = 1'b1, tick_a = 1'b0;
    logic rx_n = 1'b1, rx_o = 1'b1, rx_e = 1'b1;
    logic [7:0] d_n, d_o;
    logic [6:0] d_e;
    logic v_n, p_n, f_n, b_n, busy_n;
    logic v_o, p_o, f_o, b_o, busy_o;
    logic v_e, p_e, f_e, b_e, busy_e;
    int tests = 0, fails = 0;

    typedef struct {
        int         id;
        logic [8:0] d;
        logic       p, f, b;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) tick_a <= ~tick_a;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY("NONE"), .STOP_BITS(1), .IDLE_BITS(10)) u_n (
        .clk(clk), .rst(rst), .rx(rx_n), .os_tick(tick_a), .rx_data(d_n), .rx_valid(v_n),
        .parity_err(p_n), .frame_err(f_n), .break_det(b_n), .busy(busy_n));
    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY("ODD"), .STOP_BITS(1), .IDLE_BITS(10)) u_o (
        .clk(clk), .rst(rst), .rx(rx_o), .os_tick(tick_a), .rx_data(d_o), .rx_valid(v_o),
        .parity_err(p_o), .frame_err(f_o), .break_det(b_o), .busy(busy_o));
    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY("EVEN"), .STOP_BITS(2), .IDLE_BITS(10)) u_e (
        .clk(clk), .rst(rst), .rx(rx_e), .os_tick(1'b1), .rx_data(d_e), .rx_valid(v_e),
        .parity_err(p_e), .frame_err(f_e), .break_det(b_e), .busy(busy_e));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int id, input logic [8:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        if (q.size() == 0) begin
            chk($sformatf("unexpected_valid_u%0d", id), 1, 0);
        end else begin
            e = q.pop_front();
            chk("id", id, e.id);
            chk($sformatf("data_u%0d", id), d, e.d);
            chk($sformatf("parity_err_u%0d", id), p, e.p);
            chk($sformatf("frame_err_u%0d", id), f, e.f);
            chk($sformatf("break_det_u%0d", id), b, e.b);
        end
    endtask

    always @(negedge clk) begin
        if (v_n) mon(0, {1'b0, d_n}, p_n, f_n, b_n);
        if (v_o) mon(1, {1'b0, d_o}, p_o, f_o, b_o);
        if (v_e) mon(2, {2'b0, d_e}, p_e, f_e, b_e);
    end

    function automatic logic par_err(input logic [8:0] d, input int nb, input logic pb, input logic odd);
        logic x = pb;
        for (int i = 0; i < nb; i++) x ^= d[i];
        return odd ? (x != 1'b1) : (x != 1'b0);
    endfunction

    task automatic set_rx(input int id, input logic v);
        case (id)
            0: rx_n = v;
            1: rx_o = v;
            default: rx_e = v;
        endcase
    endtask

    // one 16-clk bit; g inverts the line for 2 clks near the vote window
    task automatic bitx(input int id, input logic v, input bit g);
        set_rx(id, v);
        if (g) begin
            repeat (11) @(negedge clk);
            set_rx(id, ~v);
            repeat (2) @(negedge clk);
            set_rx(id, v);
            repeat (3) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send(input int id, input logic [8:0] d, input int nb, input bit pe, input logic pb,
                        input int ns, input logic sv, input bit g);
        bitx(id, 1'b0, 0);
        for (int i = 0; i < nb; i++) bitx(id, d[i], g);
        if (pe) bitx(id, pb, 0);
        for (int s = 0; s < ns; s++) bitx(id, sv, 0);
        set_rx(id, 1'b1);
    endtask

    task automatic expect_frame(input int id, input logic [8:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        e.id = id; e.d = d; e.p = p; e.f = f; e.b = b;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    task automatic idle(input int nbits);
        repeat (16 * nbits) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rx_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data", d_n, 0);
        chk("rst_valid", v_n, 0);
        chk("rst_perr", p_o, 0);
        chk("rst_ferr", f_n, 0);
        chk("rst_brk", b_n, 0);
        chk("rst_busy", busy_n, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("low_after_rst_busy", busy_n, 0);
        rx_n = 1'b1;
        idle(12);

        expect_frame(1, 9'h03, par_err(9'h03, 8, 1'b1, 1'b1), 0, 0);
        send(1, 9'h03, 8, 1, 1'b1, 1, 1'b1, 0);
        drain();
        idle(1);
        expect_frame(1, 9'h03, par_err(9'h03, 8, 1'b0, 1'b1), 0, 0);
        send(1, 9'h03, 8, 1, 1'b0, 1, 1'b1, 0);
        drain();
        idle(1);
        chk("perr_hold", p_o, 1);

        expect_frame(2, 9'h7F, par_err(9'h7F, 7, 1'b1, 1'b0), 0, 0);
        expect_frame(2, 9'h00, par_err(9'h00, 7, 1'b0, 1'b0), 0, 0);
        send(2, 9'h7F, 7, 1, 1'b1, 2, 1'b1, 0);
        send(2, 9'h00, 7, 1, 1'b0, 2, 1'b1, 0);
        drain();

        expect_frame(0, 9'hA5, 0, 0, 0);
        send(0, 9'hA5, 8, 0, 1'b0, 1, 1'b1, 0);
        drain();
        idle(1);

        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("false_start_busy_rise", busy_n, 1);
        repeat (20) @(negedge clk);
        chk("false_start_busy_fall", busy_n, 0);
        idle(1);

        expect_frame(0, 9'h5A, 0, 0, 0);
        send(0, 9'h5A, 8, 0, 1'b0, 1, 1'b1, 1);
        drain();
        idle(1);

        expect_frame(0, 9'h81, 0, 1, 0);
        send(0, 9'h81, 8, 0, 1'b0, 1, 1'b0, 0);
        drain();
        repeat (8) @(negedge clk);
        chk("ferr_hold", f_n, 1);
        idle(2);

        expect_frame(0, 9'h00, 0, 1, 1);
        rx_n = 1'b0;
        repeat (480) @(negedge clk);
        chk("break_seen", q.size(), 0);
        rx_n = 1'b1;
        idle(2);
        expect_frame(0, 9'h42, 0, 0, 0);
        send(0, 9'h42, 8, 0, 1'b0, 1, 1'b1, 0);
        drain();
        idle(1);

        bitx(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) bitx(0, (i >= 2), 0);
        rx_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("busy_mid_frame", busy_n, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_data", d_n, 0);
        chk("rst_mid_busy", busy_n, 0);
        chk("rst_mid_valid", v_n, 0);
        chk("rst_mid_ferr", f_n, 0);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        bitx(0, 1'b1, 0);
        bitx(0, 1'b0, 0);
        bitx(0, 1'b0, 0);
        bitx(0, 1'b1, 0);
        send(0, 9'h11, 8, 0, 1'b0, 1, 1'b1, 0);
        repeat (48) @(negedge clk);
        chk("early_frame_ignored", d_n, 0);
        idle(12);
        expect_frame(0, 9'h3C, 0, 0, 0);
        send(0, 9'h3C, 8, 0, 1'b0, 1, 1'b1, 0);
        drain();

        chk("pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
